// File: rtl/dly_line_ctrl.sv
// Programmable sample-delay controller: circular buffer sequenced by an IDLE/FILL/RUN FSM.
// Build option: define DLY_CTRL_HOLD_EN to hold out_o during FILL instead of forcing it to zero.
module dly_line_ctrl #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              en_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] delay_i,
    input  logic              cfg_we_i,
    output logic [WIDTH-1:0]  out_o,
    output logic              valid_o,
    output logic [1:0]        state_o,
    output logic              busy_o
);

`ifdef DLY_CTRL_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        RUN  = 2'b10
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] dly;
    logic [ADDR_W-1:0] dly_new;
    logic [ADDR_W-1:0] rd_addr_p0;
    logic              wr_en_p0;
    logic [WIDTH-1:0]  mem [2**ADDR_W];

    // Output value applied on every FILL-state update.
    function automatic logic [WIDTH-1:0] fill_out(input logic [WIDTH-1:0] cur);
        return HOLD_EN ? cur : '0;
    endfunction

    // A zero request is promoted to one so the read address never aliases wptr.
    assign dly_new    = (delay_i == '0) ? ADDR_W'(1) : delay_i;
    assign rd_addr_p0 = wptr - dly;
    assign wr_en_p0   = en_i && valid_i && (state == FILL || state == RUN);
    assign state_o    = state;
    assign busy_o     = (state == FILL);

    always_ff @(posedge clk_i) begin
        if (wr_en_p0)
            mem[wptr] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            wptr     <= '0;
            fill_cnt <= '0;
            dly      <= ADDR_W'(1);
            out_o    <= '0;
            valid_o  <= 1'b0;
        end else begin
            if (cfg_we_i)
                dly <= dly_new;

            if (!en_i) begin
                state    <= IDLE;
                wptr     <= '0;
                fill_cnt <= '0;
                out_o    <= '0;
                valid_o  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= FILL;
                        wptr     <= '0;
                        fill_cnt <= '0;
                        out_o    <= '0;
                        valid_o  <= 1'b0;
                    end
                    FILL, RUN: begin
                        valid_o <= 1'b0;
                        if (valid_i)
                            wptr <= wptr + 1'b1;
                        if (cfg_we_i) begin
                            // A coincident strobe is fill sample 1; with a delay of one that already completes the fill.
                            fill_cnt <= valid_i ? ADDR_W'(1) : '0;
                            state    <= (valid_i && dly_new == ADDR_W'(1)) ? RUN : FILL;
                            out_o    <= fill_out(out_o);
                        end else if (state == FILL) begin
                            out_o <= fill_out(out_o);
                            if (valid_i) begin
                                fill_cnt <= fill_cnt + 1'b1;
                                if (fill_cnt == dly - 1'b1)
                                    state <= RUN;
                            end
                        end else if (valid_i) begin
                            out_o   <= mem[rd_addr_p0];
                            valid_o <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
